// File: rtl/mapa_write_scheduler_pkg.sv
// Shared widths, FSM encoding and map cell codes for the map RAM write scheduler.
package mapa_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 6;
  localparam int CELLS  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam logic [DATA_W-1:0] CODE_NONE  = 4'd0;
  localparam logic [DATA_W-1:0] CODE_RED   = 4'd4;
  localparam logic [DATA_W-1:0] CODE_GREEN = 4'd5;
  localparam logic [DATA_W-1:0] CODE_BLUE  = 4'd6;

  // A missing shape or colour means nothing was recognised under the robot.
  function automatic logic [DATA_W-1:0] vis_code(input logic [1:0] forma,
                                                 input logic [1:0] color);
    logic [DATA_W-1:0] code;
    if (forma == 2'd0 || color == 2'd0) begin
      code = CODE_NONE;
    end else begin
      case (color)
        2'd1:    code = CODE_RED;
        2'd2:    code = CODE_GREEN;
        default: code = CODE_BLUE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/mapa_write_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 = CPU, bit 1 = vision.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_r;
  logic [1:0] grant_s;

  // One-hot grant; on a tie the requester not granted last wins.
  always_comb begin
    grant_s = 2'b00;
    case (req)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  // Last-grant register; resets to vision so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (accept && (grant_s != 2'b00)) begin
      last_r <= grant_s[1];
    end else begin
      last_r <= last_r;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/mapa_write_scheduler.sv
// Shares the map RAM write port between CPU writes, vision-result writes and
// a full-map clear sweep. All outputs are registered.
module mapa_write_scheduler
  import mapa_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CpuReq,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuData,
  output logic              CpuAck,
  input  logic              VisReq,
  input  logic [ADDR_W-1:0] VisAddr,
  input  logic [1:0]        Forma,
  input  logic [1:0]        PromedioColor,
  output logic              VisAck,
  input  logic              ClearStart,
  input  logic [DATA_W-1:0] ClearValue,
  output logic              Busy,
  output logic [DATA_W-1:0] MapaData,
  output logic [ADDR_W-1:0] MapaAddr,
  output logic              MapaWrite
);

  state_e            state_r, state_s;
  logic              pending_r, pending_s;
  logic [ADDR_W-1:0] clr_addr_r, clr_addr_s;
  logic [DATA_W-1:0] clr_value_r, clr_value_s;
  logic [DATA_W-1:0] mapa_data_r, mapa_data_s;
  logic [ADDR_W-1:0] mapa_addr_r, mapa_addr_s;
  logic              mapa_write_r, mapa_write_s;
  logic              cpu_ack_r, cpu_ack_s;
  logic              vis_ack_r, vis_ack_s;
  logic              busy_r, busy_s;
  logic              clear_wr_s;
  logic              accept_s;
  logic [1:0]        grant_s;

  rr_arbiter2 u_arb (
    .clk    (Clock),
    .rst_n  (Reset),
    .req    ({VisReq, CpuReq}),
    .accept (accept_s),
    .grant  (grant_s)
  );

  // Next-state and next-output logic; the clear's first write (address 0) is
  // issued on the IDLE->CLEAR edge, so clr_addr then points at address 1.
  always_comb begin
    state_s      = state_r;
    pending_s    = pending_r | (ClearStart & (state_r != CLEAR));
    clr_addr_s   = clr_addr_r;
    clr_value_s  = clr_value_r;
    mapa_data_s  = mapa_data_r;
    mapa_addr_s  = mapa_addr_r;
    mapa_write_s = 1'b0;
    cpu_ack_s    = 1'b0;
    vis_ack_s    = 1'b0;
    clear_wr_s   = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_r || ClearStart) begin
          state_s      = CLEAR;
          pending_s    = 1'b1;
          clr_value_s  = ClearValue;
          clr_addr_s   = ADDR_W'(1);
          mapa_write_s = 1'b1;
          mapa_addr_s  = '0;
          mapa_data_s  = ClearValue;
          clear_wr_s   = 1'b1;
        end else if (grant_s[0]) begin
          state_s      = WRITE;
          accept_s     = 1'b1;
          mapa_write_s = 1'b1;
          mapa_addr_s  = CpuAddr;
          mapa_data_s  = CpuData;
          cpu_ack_s    = 1'b1;
        end else if (grant_s[1]) begin
          state_s      = WRITE;
          accept_s     = 1'b1;
          mapa_write_s = 1'b1;
          mapa_addr_s  = VisAddr;
          mapa_data_s  = vis_code(Forma, PromedioColor);
          vis_ack_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        state_s = IDLE;
      end
      CLEAR: begin
        mapa_write_s = 1'b1;
        mapa_addr_s  = clr_addr_r;
        mapa_data_s  = clr_value_r;
        clear_wr_s   = 1'b1;
        clr_addr_s   = clr_addr_r + ADDR_W'(1);
        if (clr_addr_r == ADDR_W'(CELLS - 1)) begin
          state_s   = IDLE;
          pending_s = 1'b0;
        end else begin
          state_s = CLEAR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // Busy stays high through the cycle that shows the final clear write.
    busy_s = pending_s | (state_s == CLEAR) | clear_wr_s;
  end

  // State, clear engine and registered output port.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r      <= IDLE;
      pending_r    <= 1'b0;
      clr_addr_r   <= '0;
      clr_value_r  <= '0;
      mapa_data_r  <= '0;
      mapa_addr_r  <= '0;
      mapa_write_r <= 1'b0;
      cpu_ack_r    <= 1'b0;
      vis_ack_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      pending_r    <= pending_s;
      clr_addr_r   <= clr_addr_s;
      clr_value_r  <= clr_value_s;
      mapa_data_r  <= mapa_data_s;
      mapa_addr_r  <= mapa_addr_s;
      mapa_write_r <= mapa_write_s;
      cpu_ack_r    <= cpu_ack_s;
      vis_ack_r    <= vis_ack_s;
      busy_r       <= busy_s;
    end
  end

  assign MapaData  = mapa_data_r;
  assign MapaAddr  = mapa_addr_r;
  assign MapaWrite = mapa_write_r;
  assign CpuAck    = cpu_ack_r;
  assign VisAck    = vis_ack_r;
  assign Busy      = busy_r;

endmodule

// File: tb/tb_mapa_write_scheduler.sv
// Directed bench for mapa_write_scheduler: vector table for single writes,
// hand sequences for contention, clear sweep and reset mid-clear.
module tb_mapa_write_scheduler;
  import mapa_pkg::*;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              CpuReq = 1'b0;
  logic [ADDR_W-1:0] CpuAddr = '0;
  logic [DATA_W-1:0] CpuData = '0;
  logic              CpuAck;
  logic              VisReq = 1'b0;
  logic [ADDR_W-1:0] VisAddr = '0;
  logic [1:0]        Forma = 2'd0;
  logic [1:0]        PromedioColor = 2'd0;
  logic              VisAck;
  logic              ClearStart = 1'b0;
  logic [DATA_W-1:0] ClearValue = '0;
  logic              Busy;
  logic [DATA_W-1:0] MapaData;
  logic [ADDR_W-1:0] MapaAddr;
  logic              MapaWrite;

  mapa_write_scheduler dut (
    .Clock(Clock), .Reset(Reset),
    .CpuReq(CpuReq), .CpuAddr(CpuAddr), .CpuData(CpuData), .CpuAck(CpuAck),
    .VisReq(VisReq), .VisAddr(VisAddr), .Forma(Forma),
    .PromedioColor(PromedioColor), .VisAck(VisAck),
    .ClearStart(ClearStart), .ClearValue(ClearValue), .Busy(Busy),
    .MapaData(MapaData), .MapaAddr(MapaAddr), .MapaWrite(MapaWrite)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cpu = 0;
  int exp_vis = 0;

  // Scoreboard: map model built from the RAM port plus grant counters.
  logic [3:0] model [64];
  int mon_cpu_acks = 0;
  int mon_vis_acks = 0;
  always @(negedge Clock) begin
    if (MapaWrite) model[MapaAddr] = MapaData;
    if (CpuAck) mon_cpu_acks++;
    if (VisAck) mon_vis_acks++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       cpu_req;
    logic [5:0] cpu_addr;
    logic [3:0] cpu_data;
    logic       vis_req;
    logic [5:0] vis_addr;
    logic [1:0] forma;
    logic [1:0] color;
    logic [5:0] e_addr;
    logic [3:0] e_data;
    logic       e_cpu;
    logic       e_vis;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{"cpu13",   1'b1, 6'd13, 4'd2,  1'b0, 6'd0,  2'd0, 2'd0, 6'd13, 4'd2,  1'b1, 1'b0};
    vecs[1] = '{"vis_g",   1'b0, 6'd0,  4'd0,  1'b1, 6'd7,  2'd1, 2'd2, 6'd7,  4'd5,  1'b0, 1'b1};
    vecs[2] = '{"vis_f0",  1'b0, 6'd0,  4'd0,  1'b1, 6'd8,  2'd0, 2'd3, 6'd8,  4'd0,  1'b0, 1'b1};
    vecs[3] = '{"vis_c0",  1'b0, 6'd0,  4'd0,  1'b1, 6'd9,  2'd2, 2'd0, 6'd9,  4'd0,  1'b0, 1'b1};
    vecs[4] = '{"vis_r",   1'b0, 6'd0,  4'd0,  1'b1, 6'd10, 2'd3, 2'd1, 6'd10, 4'd4,  1'b0, 1'b1};
    vecs[5] = '{"vis_b63", 1'b0, 6'd0,  4'd0,  1'b1, 6'd63, 2'd1, 2'd3, 6'd63, 4'd6,  1'b0, 1'b1};
    vecs[6] = '{"cpu0",    1'b1, 6'd0,  4'd15, 1'b0, 6'd0,  2'd0, 2'd0, 6'd0,  4'd15, 1'b1, 1'b0};
    vecs[7] = '{"tie_vis", 1'b1, 6'd20, 4'd3,  1'b1, 6'd21, 2'd1, 2'd1, 6'd21, 4'd4,  1'b0, 1'b1};
    vecs[8] = '{"tie_cpu", 1'b1, 6'd20, 4'd3,  1'b1, 6'd21, 2'd1, 2'd1, 6'd20, 4'd3,  1'b1, 1'b0};

    // Reset state
    tick(); tick();
    check("rst_out", 32'({MapaWrite, MapaAddr, MapaData, CpuAck, VisAck, Busy}), 32'd0);
    Reset = 1'b1;
    tick();
    check("idle_out", 32'({MapaWrite, CpuAck, VisAck, Busy}), 32'd0);

    // Single writes, one handshake per vector
    for (int i = 0; i < 9; i++) begin
      CpuReq = vecs[i].cpu_req; CpuAddr = vecs[i].cpu_addr; CpuData = vecs[i].cpu_data;
      VisReq = vecs[i].vis_req; VisAddr = vecs[i].vis_addr;
      Forma = vecs[i].forma; PromedioColor = vecs[i].color;
      tick();
      CpuReq = 1'b0; VisReq = 1'b0;
      check({vecs[i].name, "_wr"},   32'(MapaWrite), 32'd1);
      check({vecs[i].name, "_addr"}, 32'(MapaAddr), 32'(vecs[i].e_addr));
      check({vecs[i].name, "_data"}, 32'(MapaData), 32'(vecs[i].e_data));
      check({vecs[i].name, "_ack"},  32'({CpuAck, VisAck}), 32'({vecs[i].e_cpu, vecs[i].e_vis}));
      if (vecs[i].e_cpu) exp_cpu++;
      if (vecs[i].e_vis) exp_vis++;
      tick();
      check({vecs[i].name, "_hold"}, 32'({MapaWrite, CpuAck, VisAck, MapaAddr}), 32'({3'b000, vecs[i].e_addr}));
    end

    // Contention from reset: CPU first, then alternate, one write per 2 cycles
    Reset = 1'b0; tick(); Reset = 1'b1;
    CpuReq = 1'b1; CpuAddr = 6'd40; CpuData = 4'd9;
    VisReq = 1'b1; VisAddr = 6'd41; Forma = 2'd1; PromedioColor = 2'd3;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 2 == 0)
        check("rr_gap", 32'({MapaWrite, CpuAck, VisAck}), 32'd0);
      else if (c % 4 == 1)
        check("rr_cpu", 32'({MapaWrite, CpuAck, VisAck, MapaAddr, MapaData}), 32'({3'b110, 6'd40, 4'd9}));
      else
        check("rr_vis", 32'({MapaWrite, CpuAck, VisAck, MapaAddr, MapaData}), 32'({3'b101, 6'd41, 4'd6}));
    end
    CpuReq = 1'b0; VisReq = 1'b0;
    exp_cpu += 2; exp_vis += 2;
    tick();

    // Full clear with a CPU request waiting and an ignored restart mid-sweep
    ClearValue = 4'd1; ClearStart = 1'b1;
    tick();
    ClearStart = 1'b0;
    for (int k = 0; k < 64; k++) begin
      check("clr_sweep", 32'({MapaWrite, MapaAddr, MapaData, Busy, CpuAck}), 32'({1'b1, 6'(k), 4'd1, 1'b1, 1'b0}));
      if (k == 10) begin CpuReq = 1'b1; CpuAddr = 6'd33; CpuData = 4'd9; end
      ClearStart = (k == 30);
      tick();
    end
    check("clr_cpu", 32'({MapaWrite, MapaAddr, MapaData, Busy, CpuAck}), 32'({1'b1, 6'd33, 4'd9, 1'b0, 1'b1}));
    CpuReq = 1'b0; exp_cpu++;
    tick();
    check("clr_done1", 32'({MapaWrite, Busy}), 32'd0);
    tick();
    check("clr_done2", 32'({MapaWrite, Busy, CpuAck}), 32'd0);

    // Reset at address 20 aborts the sweep; a new clear restarts at 0
    ClearValue = 4'd3; ClearStart = 1'b1;
    tick();
    ClearStart = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("abort_pre", 32'({MapaWrite, MapaAddr, MapaData, Busy}), 32'({1'b1, 6'd20, 4'd3, 1'b1}));
    Reset = 1'b0;
    tick();
    check("abort_rst", 32'({MapaWrite, MapaAddr, MapaData, Busy, CpuAck, VisAck}), 32'd0);
    Reset = 1'b1;
    tick();
    check("abort_idle", 32'({MapaWrite, Busy}), 32'd0);
    ClearValue = 4'd7; ClearStart = 1'b1;
    tick();
    ClearStart = 1'b0;
    check("restart0", 32'({MapaWrite, MapaAddr, MapaData, Busy}), 32'({1'b1, 6'd0, 4'd7, 1'b1}));
    for (int k = 1; k < 64; k++) begin
      tick();
      check("restart_sweep", 32'({MapaWrite, MapaAddr, MapaData, Busy}), 32'({1'b1, 6'(k), 4'd7, 1'b1}));
    end
    tick();
    check("restart_end", 32'({MapaWrite, Busy}), 32'd0);

    // Two more writes on top of the cleared map
    CpuReq = 1'b1; CpuAddr = 6'd5; CpuData = 4'd12;
    tick(); CpuReq = 1'b0; exp_cpu++;
    check("post_cpu", 32'({CpuAck, MapaAddr, MapaData}), 32'({1'b1, 6'd5, 4'd12}));
    tick();
    VisReq = 1'b1; VisAddr = 6'd6; Forma = 2'd2; PromedioColor = 2'd1;
    tick(); VisReq = 1'b0; exp_vis++;
    check("post_vis", 32'({VisAck, MapaAddr, MapaData}), 32'({1'b1, 6'd6, 4'd4}));
    tick(); tick();

    // Scoreboard: final map contents and one grant per request
    begin
      int bad_cells;
      logic [3:0] e;
      bad_cells = 0;
      for (int i = 0; i < 64; i++) begin
        e = (i == 5) ? 4'd12 : (i == 6) ? 4'd4 : 4'd7;
        if (model[i] !== e) bad_cells++;
      end
      check("map_model", 32'(bad_cells), 32'd0);
    end
    check("cpu_grants", 32'(mon_cpu_acks), 32'(exp_cpu));
    check("vis_grants", 32'(mon_vis_acks), 32'(exp_vis));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
